priority_enc: RTL and testbench
===============================

Name: priority_enc

Overview:
- Registered priority encoder. It converts an N-bit request vector D into the encoded position of the highest-priority asserted bit, plus a valid flag.
- Priority order: D[0] is highest priority and D[N-1] is lowest.
- The encoded output is reversed: D[0] maps to code N-1 and D[N-1] maps to code 0.
- Used as a small arbitration/encode stage. Outputs are registered on clk.

Parameters:
- N, default 4: request vector width; must be at least 2.
- YW, default $clog2(N) (2 for N=4): width of the encoded output, derived from N.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- D, input, N (4): request vector; bit 0 has highest priority.
- Y, output, YW (2): registered encoded index, equal to (N-1) minus the index of the lowest set bit of D.
- valid, output, 1: registered flag; 1 when any bit of D was set at the last sampling edge.

Behaviour:
- Reset:
  - rst high clears Y to 0 and valid to 0 immediately, without waiting for a clock edge.
  - Outputs stay cleared while rst is high, regardless of D.
  - Deasserting rst takes effect at the next rising clk edge.
- Encode function (combinational, before the output register):
  - k = index of the lowest-numbered set bit in D.
  - Y_next = N-1-k; valid_next = 1.
  - For N=4: D[0]=1 gives 3; else D[1]=1 gives 2; else D[2]=1 gives 1; else D[3]=1 gives 0.
  - Only the lowest set bit counts. All higher bits are don't-care for Y.
- D == 0: Y_next = 0 and valid_next = 0. Y is forced to 0, not held.
- Latency:
  - D is sampled on each rising clk edge; Y and valid update on that same edge.
  - A change on D is visible on the outputs after exactly one rising edge, with no combinational path from D to the outputs.
  - A new result is produced every cycle, with no handshake or stall.
- Reset mid-operation: Y and valid clear at once. The first post-reset result reflects D sampled on the first rising edge with rst low.
- No internal state other than the Y and valid registers.
- X/Z on D is not required to be handled; the bench drives only 0/1 values.

Test Plan:
- Reset: drive D=4'b1000 with rst=1 and hold across a rising edge, then sample at the falling edge. Required: Y=0, valid=0. Release rst.
- Zero input: D=4'b0000, wait one rising edge, sample at the falling edge. Required: valid=0, Y=0.
- Single-bit inputs, each followed by one rising edge. Required: Y as listed, valid=1 in every case.
  - D=0001 gives Y=3.
  - D=0010 gives Y=2.
  - D=0100 gives Y=1.
  - D=1000 gives Y=0.
- Multi-bit priority, each followed by one rising edge. Required:
  - D=0011 and D=1111 give Y=3.
  - D=0110 and D=1110 give Y=2.
  - D=1100 gives Y=1.
- Exhaustive sweep: D=1..15, sampling at the falling edge after one rising edge each. Required: Y = 3 minus the index of the lowest set bit, valid=1, zero mismatches.
- Asynchronous reset mid-stream: with D=0001 and Y=3, assert rst between clock edges. Required: Y=0 and valid=0 immediately, before the next edge. After rst is released, Y=3 and valid=1 follow one rising edge later.

Source files
------------

// File: rtl/priority_enc.sv
`default_nettype none
// ============================================================================
// Module   : priority_enc
// Purpose  : Registered priority encoder. D[0] has the highest priority, and
//            the reported code is reversed, so D[k] maps to N-1-k.
// Revision : 1.0  initial release
// ============================================================================
module priority_enc #(
  parameter int N  = 4,
  parameter int YW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  D,
  output logic [YW-1:0] Y,
  output logic          valid
);

  logic [YW-1:0] y_next;
  logic          valid_next;

  // The scan runs from the lowest-priority bit to the highest, so the last
  // match is the lowest set index. An all-zero D forces the code to 0.
  always_comb begin
    y_next     = '0;
    valid_next = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (D[i]) begin
        y_next     = YW'(N - 1 - i);
        valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y     <= '0;
      valid <= 1'b0;
    end else begin
      Y     <= y_next;
      valid <= valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_enc
// Purpose  : Scoreboard bench for priority_enc. It uses directed cases, an
//            exhaustive sweep, random stimulus and an async reset check.
// Revision : 1.0  initial release
// ============================================================================
module tb_priority_enc;

  localparam int N  = 4;
  localparam int YW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  D;
  logic [YW-1:0] Y;
  logic          valid;

  int checks = 0;
  int errors = 0;

  // Each entry is {valid, Y}, and it is pushed in issue order.
  logic [YW:0] exp_q[$];

  priority_enc #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .D     (D),
    .Y     (Y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Reference: isolate the lowest set bit arithmetically and take its log2.
  function automatic logic [YW:0] model(input logic [N-1:0] d);
    int low;
    int k;
    if (d == '0) return '0;
    low = int'(d) & -int'(d);
    k   = $clog2(low);
    return {1'b1, YW'(N - 1 - k)};
  endfunction

  task automatic check(input string name, input logic [YW:0] act, input logic [YW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%b Y=%0d, expected valid=%b Y=%0d",
               name, act[YW], act[YW-1:0], exp[YW], exp[YW-1:0]);
    end
  endtask

  // Monitor: on every falling edge, compare the registered outputs with the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check("scoreboard", {valid, Y}, exp_q.pop_front());
    end
  end

  task automatic apply(input logic [N-1:0] d);
    @(negedge clk);
    #1 D = d;
    @(posedge clk);
    #1 exp_q.push_back(model(d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] dir [8];
    int wait_cycles;
    dir = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1111, 4'b0110, 4'b1100};

    rst = 1'b1;
    D   = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    check("reset_state", {valid, Y}, '0);
    #1 rst = 1'b0;

    apply('0);
    foreach (dir[i]) apply(dir[i]);
    apply(4'b1110);
    for (int d = 1; d < (1 << N); d++) apply(N'(d));
    repeat (200) apply(N'($urandom_range((1 << N) - 1)));

    // Wait for the scoreboard to empty before the async reset check.
    apply(4'b0001);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    check("pre_reset_Y3", {valid, Y}, {1'b1, 2'd3});

    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_immediate", {valid, Y}, '0);
    @(negedge clk);
    check("reset_held", {valid, Y}, '0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 exp_q.push_back(model(4'b0001));

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d entries pending, expected 0", exp_q.size());
    end

    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
